// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: digit encoding and
// the helpers that split the Booth digits evenly across pipeline stages.
// The stage record (valid, mode, a_ext, b_ext, sum) depends on the operand
// width, so its struct type is declared inside booth_mult_pipe.
package booth_pkg;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_digit_t;

    // Map the multiplier triplet {b[2k+1], b[2k], b[2k-1]} to its radix-4 digit.
    function automatic booth_digit_t booth_encode(input logic [2:0] trip);
        booth_digit_t dig;
        case (trip)
            3'b001, 3'b010: dig = P1;
            3'b011:         dig = P2;
            3'b100:         dig = M2;
            3'b101, 3'b110: dig = M1;
            default:        dig = ZERO;
        endcase
        return dig;
    endfunction

    // One extra digit covers the extension bits, so unsigned operands work too.
    function automatic int ndig(input int width);
        return width / 2 + 1;
    endfunction

    function automatic int digs_per_stage(input int width, input int stages);
        return (ndig(width) + stages - 1) / stages;
    endfunction

    function automatic int min_int(input int x, input int y);
        return (x < y) ? x : y;
    endfunction

endpackage

// File: rtl/booth_stage.sv
// Combinational accumulation of Booth digits [LO, HI) onto an incoming sum.
// Negative digits add the one's complement of the shifted multiple plus a
// carry of one, so no separate negation adder is needed.
module booth_stage
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LO         = 0,
    parameter int HI         = 1
) (
    input  logic [DATA_WIDTH+1:0]   a_ext,
    input  logic [DATA_WIDTH+1:0]   b_ext,
    input  logic [2*DATA_WIDTH-1:0] sum_in,
    output logic [2*DATA_WIDTH-1:0] sum_out
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]         a_sx;
    logic [DATA_WIDTH+2:0] b_pad;
    logic [PW-1:0]         acc;
    logic [PW-1:0]         mag;
    booth_digit_t          dig;

    // a_ext is already sign/zero-extended, so widening it further is a plain sign copy.
    assign a_sx  = {{(PW-DATA_WIDTH-2){a_ext[DATA_WIDTH+1]}}, a_ext};
    // Implicit zero below the multiplier LSB for the first triplet.
    assign b_pad = {b_ext, 1'b0};

    // Add each digit's shifted multiple of a into the running sum, modulo 2^PW.
    always_comb begin
        acc = sum_in;
        mag = '0;
        dig = ZERO;
        for (int k = LO; k < HI; k++) begin
            dig = booth_encode(b_pad[2*k +: 3]);
            case (dig)
                P1, M1:  mag = a_sx << (2*k);
                P2, M2:  mag = a_sx << (2*k + 1);
                default: mag = '0;
            endcase
            if (dig == M1 || dig == M2) begin
                acc = acc + ~mag + PW'(1);
            end else begin
                acc = acc + mag;
            end
        end
        sum_out = acc;
    end

endmodule

// File: rtl/booth_mult_pipe.sv
// Fully pipelined radix-4 Booth multiplier with valid/ready flow control.
// Stage 0 registers the extended operands; stages 1..STAGES each add a slice
// of the Booth digits. A single global enable stalls the whole pipe when the
// output holds a result that downstream has not taken.
module booth_mult_pipe
    import booth_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    input  logic                    i_signed,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [2*DATA_WIDTH-1:0] o_c
);

    localparam int NDIG = ndig(DATA_WIDTH);
    localparam int DPS  = digs_per_stage(DATA_WIDTH, STAGES);
    localparam int XW   = DATA_WIDTH + 2;
    localparam int PW   = 2 * DATA_WIDTH;

    typedef struct packed {
        logic          valid;
        logic          mode;
        logic [XW-1:0] a_ext;
        logic [XW-1:0] b_ext;
        logic [PW-1:0] sum;
    } stage_t;

    stage_t        pipe_q [STAGES+1];
    stage_t        pipe_d [STAGES+1];
    logic [PW-1:0] stage_sum [1:STAGES];
    logic          en;
    logic          ext_bit;

    // The pipe moves whenever the output slot is empty or being drained.
    assign en      = !pipe_q[STAGES].valid || i_ready;
    assign o_ready = en && !rst;
    assign ext_bit = i_signed;

    // Next contents of every stage: operands enter stage 0, sums advance one stage.
    always_comb begin
        pipe_d[0].valid = i_valid && o_ready;
        pipe_d[0].mode  = i_signed;
        pipe_d[0].a_ext = {{2{ext_bit && i_a[DATA_WIDTH-1]}}, i_a};
        pipe_d[0].b_ext = {{2{ext_bit && i_b[DATA_WIDTH-1]}}, i_b};
        pipe_d[0].sum   = '0;
        for (int s = 1; s <= STAGES; s++) begin
            pipe_d[s]     = pipe_q[s-1];
            pipe_d[s].sum = stage_sum[s];
        end
    end

    // Stage registers: cleared on reset, loaded together on every enabled edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s <= STAGES; s++) begin
                pipe_q[s] <= '0;
            end
        end else if (en) begin
            for (int s = 0; s <= STAGES; s++) begin
                pipe_q[s] <= pipe_d[s];
            end
        end
    end

    generate
        for (genvar gi = 1; gi <= STAGES; gi++) begin : g_stage
            localparam int LO = min_int((gi - 1) * DPS, NDIG);
            localparam int HI = min_int(gi * DPS, NDIG);
            booth_stage #(
                .DATA_WIDTH(DATA_WIDTH),
                .LO        (LO),
                .HI        (HI)
            ) u_stage (
                .a_ext  (pipe_q[gi-1].a_ext),
                .b_ext  (pipe_q[gi-1].b_ext),
                .sum_in (pipe_q[gi-1].sum),
                .sum_out(stage_sum[gi])
            );
        end
    endgenerate

    assign o_valid = pipe_q[STAGES].valid;
    assign o_c     = pipe_q[STAGES].sum;

endmodule
